// File: rtl/dacc_if.sv
// dacc_if: control bundle between the dacc sequencer and its memory/datapath.
// master: sequencer side (start/instr/mem_ready/acc_zero in; selects, strobes, ir, halted, illegal, state out).
// slave: datapath/memory side, with the directions reversed.
interface dacc_if;
  logic        start;
  logic [15:0] instr;
  logic        mem_ready;
  logic        acc_zero;
  logic [1:0]  pc_sel;
  logic [1:0]  alu_b_sel;
  logic [1:0]  acc_wr_sel;
  logic        acc_sel;
  logic        alu_op;
  logic        pc_we;
  logic        acc_we;
  logic        mem_rd;
  logic        mem_we;
  logic [15:0] ir;
  logic        halted;
  logic        illegal;
  logic [2:0]  state;
  modport master (
    input  start, instr, mem_ready, acc_zero,
    output pc_sel, alu_b_sel, acc_wr_sel, acc_sel, alu_op, pc_we, acc_we, mem_rd, mem_we, ir, halted, illegal, state
  );
  modport slave (
    output start, instr, mem_ready, acc_zero,
    input  pc_sel, alu_b_sel, acc_wr_sel, acc_sel, alu_op, pc_we, acc_we, mem_rd, mem_we, ir, halted, illegal, state
  );
endinterface

// File: rtl/dacc_control.sv
// dacc_control: multi-cycle fetch/decode/exec/mem/writeback sequencer for the 16-bit double-accumulator core.
// Ports: clk; reset (synchronous, active-high); bus (dacc_if.master) carrying start, instr, mem_ready,
//   acc_zero in and pc_sel, alu_b_sel, acc_wr_sel, acc_sel, alu_op, pc_we, acc_we, mem_rd, mem_we,
//   ir, halted, illegal, state out.
// Define DACC_CTRL_BRANCH_EN to decode opcode 7 as BZ; otherwise opcode 7 is illegal.
module dacc_control #(
  parameter int OPW           = 4,
  parameter bit START_PC_HOLD = 1'b1
) (
  input logic    clk,
  input logic    reset,
  dacc_if.master bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5, HALT = 3'd6} state_e;
  state_e state_q, state_d;
  logic [15:0] ir_q;
  logic [OPW-1:0] op;
  logic is_nop, is_add, is_sub, is_ldi, is_ld, is_st, is_jmp, is_bz, is_mov, is_halt, is_alu, legal;
  logic [1:0] pc_sel, alu_b_sel, acc_wr_sel;
  logic alu_op, pc_we, acc_we, mem_rd, mem_we, illegal;
  assign op      = ir_q[15 -: OPW];
  assign is_nop  = op == OPW'(0);
  assign is_add  = op == OPW'(1);
  assign is_sub  = op == OPW'(2);
  assign is_ldi  = op == OPW'(3);
  assign is_ld   = op == OPW'(4);
  assign is_st   = op == OPW'(5);
  assign is_jmp  = op == OPW'(6);
`ifdef DACC_CTRL_BRANCH_EN
  assign is_bz   = op == OPW'(7);
`else
  assign is_bz   = 1'b0;
`endif
  assign is_mov  = op == OPW'(8);
  assign is_halt = op == OPW'(15);
  assign is_alu  = is_add | is_sub;
  assign legal   = is_nop | is_alu | is_ldi | is_ld | is_st | is_jmp | is_bz | is_mov | is_halt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= START_PC_HOLD ? IDLE : FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && bus.mem_ready) ir_q <= bus.instr;
    end
  end
  always_comb begin
    state_d    = state_q;
    pc_sel     = 2'b10;
    alu_b_sel  = 2'b00;
    acc_wr_sel = 2'b00;
    alu_op     = 1'b0;
    pc_we      = 1'b0;
    acc_we     = 1'b0;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      IDLE: state_d = bus.start ? FETCH : IDLE;
      FETCH: begin
        mem_rd  = 1'b1;
        pc_sel  = bus.mem_ready ? 2'b00 : 2'b10;
        pc_we   = bus.mem_ready;
        state_d = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        illegal = ~legal;
        state_d = (is_alu | is_jmp | is_bz) ? EXEC :
                  (is_ldi | is_mov)         ? WB   :
                  (is_ld | is_st)           ? MEM  :
                  is_halt                   ? HALT : FETCH;
      end
      EXEC: begin
        alu_b_sel = is_alu ? 2'b01 : 2'b00;
        alu_op    = is_sub;
        pc_sel    = (is_jmp | is_bz) ? 2'b01 : 2'b10;
        pc_we     = is_jmp | (is_bz & bus.acc_zero);
        state_d   = is_alu ? WB : FETCH;
      end
      MEM: begin
        mem_rd  = is_ld;
        mem_we  = is_st;
        state_d = !bus.mem_ready ? MEM : is_ld ? WB : FETCH;
      end
      WB: begin
        acc_we     = 1'b1;
        acc_wr_sel = is_ld ? 2'b10 : is_ldi ? 2'b01 : is_mov ? 2'b11 : 2'b00;
        state_d    = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  // Strobes are forced low while reset is held so no write escapes the reset cycle.
  assign bus.pc_we      = pc_we & ~reset;
  assign bus.acc_we     = acc_we & ~reset;
  assign bus.mem_rd     = mem_rd & ~reset;
  assign bus.mem_we     = mem_we & ~reset;
  assign bus.pc_sel     = pc_sel;
  assign bus.alu_b_sel  = alu_b_sel;
  assign bus.acc_wr_sel = acc_wr_sel;
  assign bus.alu_op     = alu_op;
  assign bus.illegal    = illegal;
  assign bus.acc_sel    = ir_q[11];
  assign bus.ir         = ir_q;
  assign bus.halted     = state_q == HALT;
  assign bus.state      = state_q;
endmodule
